ring_decoder_monitor: RTL and testbench

RING_DECODER_MONITOR -- requirements
Module: ring_decoder_monitor

---
 rtl/ring_decoder_monitor.sv | 60 ++++++
 tb/tb_ring_decoder_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder_monitor.sv
// ring_decoder_monitor: samples a one-hot ring, reports the hot index and tracks sequence lock.
// Define RING_MON_ERRCNT_EN to add the saturating ERR_CNT violation counter.
module ring_decoder_monitor #(
  parameter int WIDTH = 4,
  parameter int LOCK_CNT = 3,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] RING_IN,
`ifdef RING_MON_ERRCNT_EN
  output logic [7:0]       ERR_CNT,
`endif
  output logic [IW-1:0]    IDX,
  output logic             VALID,
  output logic             LOCK,
  output logic             SEQ_ERR
);
  localparam logic [1:0] SEARCH = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2;
  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_inc;
  logic one_hot, adv, viol;
  logic [IW-1:0] hot_idx, idx_succ;
  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (RING_IN[i]) hot_idx = IW'(i);
    one_hot = (RING_IN != '0) && ((RING_IN & (RING_IN - WIDTH'(1))) == '0);
    idx_succ = (IDX == IW'(WIDTH - 1)) ? '0 : IDX + IW'(1);
    adv = one_hot && (hot_idx == idx_succ);
    cnt_inc = cnt + 4'd1;
    viol = (state == LOCKED) && !adv;
    // a one-hot miss in CONFIRM re-anchors; anything but an advance drops LOCKED to SEARCH
    state_nxt = (state == SEARCH)  ? (one_hot ? CONFIRM : SEARCH) :
                (state == CONFIRM) ? (!one_hot ? SEARCH :
                                      (adv && cnt_inc == 4'(LOCK_CNT)) ? LOCKED : CONFIRM) :
                (adv ? LOCKED : SEARCH);
  end
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      state <= SEARCH;
      cnt <= '0;
      IDX <= '0;
      VALID <= 1'b0;
      LOCK <= 1'b0;
      SEQ_ERR <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == CONFIRM && adv) ? cnt_inc : '0;
      VALID <= one_hot;
      if (one_hot) IDX <= hot_idx;
      LOCK <= state_nxt == LOCKED;
      SEQ_ERR <= viol;
    end
`ifdef RING_MON_ERRCNT_EN
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) ERR_CNT <= '0;
    else if (viol && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
`endif
endmodule

// File: tb/tb_ring_decoder_monitor.sv
// tb_ring_decoder_monitor: random and directed stimulus against a streak-based reference model.
// Covers ERR_CNT only when RING_MON_ERRCNT_EN is defined.
module tb_ring_decoder_monitor;
  localparam int W = 4, L = 3;
  logic CLK = 1'b0, CLR = 1'b0;
  logic [W-1:0] RING_IN = '0;
  logic [1:0] IDX;
  logic VALID, LOCK, SEQ_ERR;
  int vectors = 0, miscompares = 0;
  int m_streak = -1, m_idx = 0, m_cnt = 0;
  bit m_valid = 0, m_err = 0;
`ifdef RING_MON_ERRCNT_EN
  logic [7:0] ERR_CNT;
  wire [12:0] obs = {ERR_CNT, IDX, VALID, LOCK, SEQ_ERR};
  function automatic logic [12:0] expv();
    return {8'(m_cnt), 2'(m_idx), m_valid, m_streak >= L, m_err};
  endfunction
`else
  wire [4:0] obs = {IDX, VALID, LOCK, SEQ_ERR};
  function automatic logic [4:0] expv();
    return {2'(m_idx), m_valid, m_streak >= L, m_err};
  endfunction
`endif

  ring_decoder_monitor #(.WIDTH(W), .LOCK_CNT(L)) dut (
    .CLK(CLK), .CLR(CLR), .RING_IN(RING_IN),
`ifdef RING_MON_ERRCNT_EN
    .ERR_CNT(ERR_CNT),
`endif
    .IDX(IDX), .VALID(VALID), .LOCK(LOCK), .SEQ_ERR(SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_streak = -1; m_idx = 0; m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  // streak: -1 searching, 0 anchored, n = n consecutive correct advances (capped at L once locked)
  task automatic model_step(input logic [W-1:0] v);
    bit oh, locked;
    int h;
    oh = $countones(v) == 1;
    h = 0;
    for (int i = 0; i < W; i++) if (v[i]) h = i;
    locked = m_streak >= L;
    m_err = 0;
    if (oh && m_streak >= 0 && h == (m_idx + 1) % W) m_streak = locked ? L : m_streak + 1;
    else if (locked) begin m_err = 1; m_streak = -1; end
    else m_streak = oh ? 0 : -1;
    m_valid = oh;
    if (oh) m_idx = h;
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic apply(input logic [W-1:0] v);
    @(negedge CLK) RING_IN = v;
    @(posedge CLK) model_step(v);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge CLK) begin CLR = 1'b0; RING_IN = '0; end
    model_reset();
    @(negedge CLK) CLR = 1'b1;
    @(posedge CLK) model_step('0);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK) RING_IN = W'($urandom);
      @(posedge CLK) #1;
      vectors++;
      if (obs !== '0) begin miscompares++; $display("FAIL reset_hold %0d: got %b want 0", i, obs); end
    end
    reset_dut();
  endtask

  task automatic test_lock_sequence();
    logic [W-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL lock_seq %0d: got %b want %b", i, obs, expv()); end
    end
    vectors++;
    if ({IDX, VALID, LOCK, SEQ_ERR} !== 5'b00110) begin
      miscompares++; $display("FAIL lock_seq_final: got %b want 00110", {IDX, VALID, LOCK, SEQ_ERR});
    end
  endtask

  task automatic test_skip();
    logic [W-1:0] seq [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      apply(seq[i]);
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL skip %0d: got %b want %b", i, obs, expv()); end
    end
    vectors++;
    if ({IDX, VALID, LOCK, SEQ_ERR} !== 5'b11101) begin
      miscompares++; $display("FAIL skip_err: got %b want 11101", {IDX, VALID, LOCK, SEQ_ERR});
    end
    apply(4'b0001);
    vectors++;
    if (SEQ_ERR !== 1'b0) begin miscompares++; $display("FAIL skip_one_pulse: got %b want 0", SEQ_ERR); end
  endtask

  task automatic test_stall();
    logic [W-1:0] seq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0000};
    int pulses = 0;
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      apply(seq[i]);
      pulses += int'(SEQ_ERR);
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL stall %0d: got %b want %b", i, obs, expv()); end
    end
    vectors++;
    if ({IDX, VALID, LOCK, SEQ_ERR} !== 5'b10000 || pulses != 1) begin
      miscompares++; $display("FAIL stall_final: got %b pulses %0d want 10000 pulses 1", {IDX, VALID, LOCK, SEQ_ERR}, pulses);
    end
  endtask

  task automatic test_confirm_abort();
    logic [W-1:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      apply(seq[i]);
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL confirm_abort %0d: got %b want %b", i, obs, expv()); end
      if (i == 3 || i == 6) begin
        vectors++;
        if (LOCK !== 1'b0 || SEQ_ERR !== 1'b0) begin
          miscompares++; $display("FAIL confirm_abort_nolock %0d: got lock %b err %b want 0 0", i, LOCK, SEQ_ERR);
        end
      end
    end
    vectors++;
    if (LOCK !== 1'b1) begin miscompares++; $display("FAIL confirm_relock: got %b want 1", LOCK); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset_dut();
    for (int i = 0; i < 4; i++) apply(seq[i]);
    vectors++;
    if (LOCK !== 1'b1) begin miscompares++; $display("FAIL async_prelock: got %b want 1", LOCK); end
    #2 CLR = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL async_clear: got %b want 0", obs); end
    @(negedge CLK) begin CLR = 1'b1; RING_IN = 4'b0100; end
    @(posedge CLK) model_step(4'b0100);
    #1;
    vectors++;
    if (obs !== expv() || {IDX, VALID, LOCK, SEQ_ERR} !== 5'b10100) begin
      miscompares++; $display("FAIL async_release: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int r;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      v = (r < 60) ? W'(1) << ((m_idx + 1) % W) :
          (r < 75) ? W'(1) << $urandom_range(W - 1) :
          (r < 85) ? W'(1) << m_idx : W'($urandom);
      apply(v);
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL random %0d in %b: got %b want %b", i, v, obs, expv()); end
    end
  endtask

`ifdef RING_MON_ERRCNT_EN
  task automatic test_errcnt_saturation();
    logic [W-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    reset_dut();
    for (int n = 0; n < 300; n++)
      for (int i = 0; i < 5; i++) begin
        apply(seq[i]);
        vectors++;
        if (obs !== expv()) begin miscompares++; $display("FAIL errcnt %0d.%0d: got %b want %b", n, i, obs, expv()); end
      end
    vectors++;
    if (ERR_CNT !== 8'd255) begin miscompares++; $display("FAIL errcnt_sat: got %0d want 255", ERR_CNT); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_sequence();
    test_skip();
    test_stall();
    test_confirm_abort();
    test_async_reset();
    test_random();
`ifdef RING_MON_ERRCNT_EN
    test_errcnt_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
